// File: rtl/wash_sequencer.sv
// Programme-timing stage of the washing machine controller: sequences the wash,
// rinse and spin stages through fill/agitate/drain/spin phases on a 1 s tick.
module wash_sequencer #(
  parameter int CLK_PER_SEC = 100_000_000,
  parameter int WASH_T      = 9,
  parameter int RINSE_T     = 6,
  parameter int SPIN_T      = 6,
  parameter int DRAIN_T     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power,
  input  logic [1:0] run_state,
  input  logic [2:0] model,
  input  logic [2:0] water,
  output logic       inwater_light,
  output logic       outwater_light,
  output logic [1:0] current_program,
  output logic [6:0] current_time,
  output logic [6:0] total_time,
  output logic       finish
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_AGITATE,
    S_DRAIN,
    S_SPIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    STG_WASH,
    STG_RINSE,
    STG_SPIN
  } stage_e;

  localparam int              PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [1:0]      RUN_GO     = 2'b01;
  localparam logic [1:0]      RUN_PAUSE  = 2'b10;
  localparam logic [2:0]      POS_DONE   = 3'd7;

  // The programme is a linear list of positions: 0-2 wash fill/agitate/drain,
  // 3-5 rinse fill/agitate/drain, 6 spin, 7 done. Disabled or 0-length ones are skipped.
  function automatic logic [7:0] pos_len(input logic [2:0] pos, input logic [2:0] wat);
    case (pos)
      3'd0, 3'd3: pos_len = {5'd0, wat};
      3'd1:       pos_len = 8'(WASH_T);
      3'd4:       pos_len = 8'(RINSE_T);
      3'd2, 3'd5: pos_len = 8'(DRAIN_T);
      3'd6:       pos_len = 8'(SPIN_T);
      default:    pos_len = 8'd0;
    endcase
  endfunction

  function automatic logic pos_enabled(input logic [2:0] pos, input logic [2:0] mask,
                                       input logic [2:0] wat);
    logic stage_on;
    case (pos)
      3'd0, 3'd1, 3'd2: stage_on = mask[2];
      3'd3, 3'd4, 3'd5: stage_on = mask[1];
      3'd6:             stage_on = mask[0];
      default:          stage_on = 1'b0;
    endcase
    pos_enabled = stage_on && (pos_len(pos, wat) != 8'd0);
  endfunction

  function automatic logic [2:0] next_pos(input logic [3:0] from, input logic [2:0] mask,
                                          input logic [2:0] wat);
    next_pos = POS_DONE;
    for (int p = 6; p >= 0; p--) begin
      if (p >= int'(from) && pos_enabled(3'(p), mask, wat)) next_pos = 3'(p);
    end
  endfunction

  function automatic state_e pos_state(input logic [2:0] pos);
    case (pos)
      3'd0, 3'd3: pos_state = S_FILL;
      3'd1, 3'd4: pos_state = S_AGITATE;
      3'd2, 3'd5: pos_state = S_DRAIN;
      3'd6:       pos_state = S_SPIN;
      default:    pos_state = S_DONE;
    endcase
  endfunction

  function automatic stage_e pos_stage(input logic [2:0] pos);
    case (pos)
      3'd0, 3'd1, 3'd2: pos_stage = STG_WASH;
      3'd3, 3'd4, 3'd5: pos_stage = STG_RINSE;
      default:          pos_stage = STG_SPIN;
    endcase
  endfunction

  function automatic logic [2:0] pos_of(input state_e st, input stage_e stg);
    logic [2:0] base;
    base = (stg == STG_RINSE) ? 3'd3 : 3'd0;
    case (st)
      S_FILL:    pos_of = base;
      S_AGITATE: pos_of = base + 3'd1;
      S_DRAIN:   pos_of = base + 3'd2;
      default:   pos_of = 3'd6;
    endcase
  endfunction

  function automatic logic [6:0] total_of(input logic [2:0] mask, input logic [2:0] wat);
    logic [9:0] sum;
    sum = '0;
    if (mask[2]) sum = sum + 10'(wat) + 10'(WASH_T) + 10'(DRAIN_T);
    if (mask[1]) sum = sum + 10'(wat) + 10'(RINSE_T) + 10'(DRAIN_T);
    if (mask[0]) sum = sum + 10'(SPIN_T);
    total_of = (sum > 10'd127) ? 7'd127 : sum[6:0];
  endfunction

  state_e        state_q, state_d;
  stage_e        stage_q, stage_d;
  logic [7:0]    phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    model_q, model_d;
  logic [2:0]    water_q, water_d;
  logic [6:0]    ctime_q, ctime_d;
  logic [6:0]    ttime_q, ttime_d;
  logic          inwater_q, inwater_d;
  logic          outwater_q, outwater_d;
  logic [1:0]    prog_q, prog_d;
  logic          finish_q, finish_d;

  logic [2:0] model_eff;
  logic [2:0] water_eff;
  logic [6:0] preview;
  logic       tick;
  logic       enter;
  logic [2:0] nxt;
  logic [2:0] enter_wat;

  assign model_eff = (model == 3'b000) ? 3'b111 : model;
  assign water_eff = (water == 3'd0) ? 3'd1 : water;
  assign preview   = total_of(model_eff, water_eff);

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    phase_d   = phase_q;
    presc_d   = presc_q;
    model_d   = model_q;
    water_d   = water_q;
    ctime_d   = ctime_q;
    ttime_d   = ttime_q;
    tick      = 1'b0;
    enter     = 1'b0;
    nxt       = POS_DONE;
    enter_wat = water_q;

    if (!power) begin
      state_d = S_IDLE;
      presc_d = '0;
      phase_d = '0;
      ctime_d = preview;
      ttime_d = preview;
    end else begin
      case (state_q)
        S_IDLE: begin
          ctime_d = preview;
          ttime_d = preview;
          if (run_state == RUN_GO) begin
            model_d   = model_eff;
            water_d   = water_eff;
            presc_d   = '0;
            nxt       = next_pos(4'd0, model_eff, water_eff);
            enter_wat = water_eff;
            enter     = 1'b1;
          end
        end
        S_DONE: begin
          if (run_state != RUN_GO && run_state != RUN_PAUSE) begin
            state_d = S_IDLE;
            ctime_d = preview;
            ttime_d = preview;
          end
        end
        default: begin
          if (run_state == RUN_GO) begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              phase_d = phase_q - 8'd1;
              if (ctime_q != 7'd0) ctime_d = ctime_q - 7'd1;
              // Phase expiry loads the next non-empty position in the same cycle.
              if (phase_q <= 8'd1) begin
                nxt   = next_pos({1'b0, pos_of(state_q, stage_q)} + 4'd1, model_q, water_q);
                enter = 1'b1;
              end
            end
          end else if (run_state != RUN_PAUSE) begin
            state_d = S_IDLE;
            presc_d = '0;
            phase_d = '0;
            ctime_d = preview;
            ttime_d = preview;
          end
        end
      endcase
    end

    if (enter) begin
      state_d = pos_state(nxt);
      stage_d = pos_stage(nxt);
      phase_d = pos_len(nxt, enter_wat);
    end
    if (state_d == S_DONE) ctime_d = 7'd0;

    inwater_d  = (state_d == S_FILL);
    outwater_d = (state_d == S_DRAIN);
    finish_d   = (state_d == S_DONE);
    case (state_d)
      S_FILL, S_AGITATE, S_DRAIN: prog_d = (stage_d == STG_RINSE) ? 2'b10 : 2'b01;
      S_SPIN:                     prog_d = 2'b11;
      default:                    prog_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      stage_q    <= STG_WASH;
      phase_q    <= '0;
      presc_q    <= '0;
      model_q    <= '0;
      water_q    <= '0;
      ctime_q    <= '0;
      ttime_q    <= '0;
      inwater_q  <= 1'b0;
      outwater_q <= 1'b0;
      prog_q     <= 2'b00;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      model_q    <= model_d;
      water_q    <= water_d;
      ctime_q    <= ctime_d;
      ttime_q    <= ttime_d;
      inwater_q  <= inwater_d;
      outwater_q <= outwater_d;
      prog_q     <= prog_d;
      finish_q   <= finish_d;
    end
  end

  assign inwater_light   = inwater_q;
  assign outwater_light  = outwater_q;
  assign current_program = prog_q;
  assign current_time    = ctime_q;
  assign total_time      = ttime_q;
  assign finish          = finish_q;

endmodule
